serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 96 +++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and result acceptance; slave is the subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, diff, borrow_out, ovf, out_valid, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, diff, borrow_out, ovf, out_valid, busy
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per cycle: result valid WIDTH cycles after accept.
// Result holds under out_ready=0; a new operand pair is taken only in IDLE (WIDTH+2 cycle cadence).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave io
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res;
   logic [CW-1:0]    cnt;
   logic             br, a_msb, b_msb;
   logic             d, br_nxt, last;

   assign d      = a_sh[0] ^ b_sh[0] ^ br;
   assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
   assign last   = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      io.in_ready  = 1'b0;
      io.busy      = 1'b0;
      io.out_valid = 1'b0;
      case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            if (io.in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            io.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            io.out_valid = 1'b1;
            if (io.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh          <= '0;
         b_sh          <= '0;
         res           <= '0;
         cnt           <= '0;
         br            <= 1'b0;
         a_msb         <= 1'b0;
         b_msb         <= 1'b0;
         io.diff       <= '0;
         io.borrow_out <= 1'b0;
         io.ovf        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  a_sh  <= io.a;
                  b_sh  <= io.b;
                  a_msb <= io.a[WIDTH-1];
                  b_msb <= io.b[WIDTH-1];
                  br    <= 1'b0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nxt;
               cnt  <= cnt + CW'(1);
               // res keeps the WIDTH-1 lower result bits; the final bit lands straight in diff
               res  <= (WIDTH-1)'({d, res} >> 1);
               if (last) begin
                  io.diff       <= {d, res};
                  io.borrow_out <= br_nxt;
                  io.ovf        <= (a_msb != b_msb) && (d != a_msb);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
